rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters: ALU (req 0) and load/MEM (req 1).

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_wb_slot.sv | 60 ++++++
 rtl/rf_wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   RF_AW / RF_DW : default register address and data widths
//   REG_ZERO      : hard-wired zero register, never written
//   req_e         : requester index (ALU = 0, MEM/load = 1)
package rf_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 32;

  localparam logic [RF_AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding register.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture addr_in/data_in and mark full (wins over clear)
//   clear      : free the slot (granted or flushed)
//   addr_in    : destination register to capture
//   data_in    : data to capture
//   full       : slot holds a pending write
//   addr, data : held destination register and data
module rf_wb_slot
  import rf_pkg::*;
#(
  parameter int unsigned AW = RF_AW,
  parameter int unsigned DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  output logic          full,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic          full_q, full_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  // Load beats clear so a slot can be granted and refilled on the same edge.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      addr_d = addr_in;
      data_d = data_in;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter for two writeback requesters (ALU, MEM).
// Each requester owns a one-entry slot; the older full slot commits first so
// program order to a register is preserved. The write port is registered.
// A combinational lookup reports pending writes with forwarded data.
//   clock_in, rst_n         : clock, asynchronous active-low reset
//   flush                   : discard both slots, drop this edge's handshakes
//   alu_valid/ready/addr/data, mem_valid/ready/addr/data : requester handshakes
//   regWrite/writeReg/writeData : registered register-file write port
//   rd_addr1/2 -> hit1/2, fwd1/2 : pending-write lookup with youngest data
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned AW      = RF_AW,
  parameter int unsigned DW      = RF_DW,
  parameter bit          TIE_MEM = 1'b1
) (
  input  logic          clock_in,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          regWrite,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] writeData,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          hit1,
  output logic          hit2,
  output logic [DW-1:0] fwd1,
  output logic [DW-1:0] fwd2
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic          alu_full, mem_full;
  logic [AW-1:0] alu_slot_addr, mem_slot_addr;
  logic [DW-1:0] alu_slot_data, mem_slot_data;

  // age_q = 1: MEM slot is older than ALU slot (meaningful only when both full)
  logic age_q, age_d;

  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] write_reg_q, write_reg_d;
  logic [DW-1:0] write_data_q, write_data_d;

  logic win_valid;
  req_e win_sel;
  logic alu_grant, mem_grant;
  logic alu_load, mem_load;
  logic commit;

  // Oldest-first arbitration over full slots.
  always_comb begin
    win_valid = alu_full || mem_full;
    win_sel   = REQ_ALU;
    if (alu_full && mem_full) begin
      win_sel = age_q ? REQ_MEM : REQ_ALU;
    end else if (mem_full) begin
      win_sel = REQ_MEM;
    end
    alu_grant = win_valid && (win_sel == REQ_ALU);
    mem_grant = win_valid && (win_sel == REQ_MEM);
  end

  // Ready is forced low while reset is asserted.
  assign alu_ready = rst_n && (!alu_full || alu_grant);
  assign mem_ready = rst_n && (!mem_full || mem_grant);

  // Writes to the zero register complete the handshake but are dropped here.
  assign alu_load = alu_valid && alu_ready && !flush && (alu_addr != ZERO_ADDR);
  assign mem_load = mem_valid && mem_ready && !flush && (mem_addr != ZERO_ADDR);
  assign commit   = win_valid && !flush;

  rf_wb_slot #(.AW(AW), .DW(DW)) u_alu_slot (
    .clk     (clock_in),
    .rst_n   (rst_n),
    .load    (alu_load),
    .clear   (alu_grant || flush),
    .addr_in (alu_addr),
    .data_in (alu_data),
    .full    (alu_full),
    .addr    (alu_slot_addr),
    .data    (alu_slot_data)
  );

  rf_wb_slot #(.AW(AW), .DW(DW)) u_mem_slot (
    .clk     (clock_in),
    .rst_n   (rst_n),
    .load    (mem_load),
    .clear   (mem_grant || flush),
    .addr_in (mem_addr),
    .data_in (mem_data),
    .full    (mem_full),
    .addr    (mem_slot_addr),
    .data    (mem_slot_data)
  );

  // Age tracking: a slot that stays full is older than one that refills.
  always_comb begin
    age_d = age_q;
    if (flush) begin
      age_d = 1'b0;
    end else if (alu_load && mem_load) begin
      age_d = TIE_MEM;
    end else if (alu_load && mem_full && !mem_grant) begin
      age_d = 1'b1;
    end else if (mem_load && alu_full && !alu_grant) begin
      age_d = 1'b0;
    end
  end

  // Output stage: address/data hold when idle.
  always_comb begin
    reg_write_d  = commit;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (commit) begin
      if (win_sel == REQ_MEM) begin
        write_reg_d  = mem_slot_addr;
        write_data_d = mem_slot_data;
      end else begin
        write_reg_d  = alu_slot_addr;
        write_data_d = alu_slot_data;
      end
    end
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      age_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      age_q        <= age_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;

  // Returns {hit, data}; when both slots match the younger slot's data wins.
  function automatic logic [DW:0] lookup(
    input logic [AW-1:0] rd,
    input logic          a_full,
    input logic [AW-1:0] a_addr,
    input logic [DW-1:0] a_data,
    input logic          m_full,
    input logic [AW-1:0] m_addr,
    input logic [DW-1:0] m_data,
    input logic          mem_older
  );
    logic a_hit;
    logic m_hit;
    logic [DW-1:0] d;
    a_hit = a_full && (a_addr == rd) && (rd != ZERO_ADDR);
    m_hit = m_full && (m_addr == rd) && (rd != ZERO_ADDR);
    d     = '0;
    if (a_hit && m_hit) begin
      d = mem_older ? a_data : m_data;
    end else if (a_hit) begin
      d = a_data;
    end else if (m_hit) begin
      d = m_data;
    end
    return {a_hit || m_hit, d};
  endfunction

  always_comb begin
    {hit1, fwd1} = lookup(rd_addr1, alu_full, alu_slot_addr, alu_slot_data,
                          mem_full, mem_slot_addr, mem_slot_data, age_q);
    {hit2, fwd2} = lookup(rd_addr2, alu_full, alu_slot_addr, alu_slot_data,
                          mem_full, mem_slot_addr, mem_slot_data, age_q);
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: dut uses TIE_MEM=1, dut0 uses TIE_MEM=0.
module tb_rf_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush;
  logic [AW-1:0] rd1, rd2;

  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr, writeReg;
  logic [DW-1:0] alu_data, mem_data, writeData, fwd1, fwd2;
  logic          regWrite, hit1, hit2;

  logic          b_alu_valid, b_alu_ready, b_mem_valid, b_mem_ready;
  logic [AW-1:0] b_alu_addr, b_mem_addr, b_writeReg;
  logic [DW-1:0] b_alu_data, b_mem_data, b_writeData, b_fwd1, b_fwd2;
  logic          b_regWrite, b_hit1, b_hit2;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .TIE_MEM(1'b1)) dut (
    .clock_in(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .rd_addr1(rd1), .rd_addr2(rd2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2)
  );

  rf_wb_arbiter #(.AW(AW), .DW(DW), .TIE_MEM(1'b0)) dut0 (
    .clock_in(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(b_alu_valid), .alu_ready(b_alu_ready), .alu_addr(b_alu_addr), .alu_data(b_alu_data),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .regWrite(b_regWrite), .writeReg(b_writeReg), .writeData(b_writeData),
    .rd_addr1(rd1), .rd_addr2(rd2), .hit1(b_hit1), .hit2(b_hit2), .fwd1(b_fwd1), .fwd2(b_fwd2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Scoreboard: expected commits per DUT, in commit order.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t q1[$];
  wr_t q0[$];
  int  ncommit1 = 0;
  int  ncommit0 = 0;

  function automatic wr_t wr(input int a, input int d);
    wr_t w;
    w.a = AW'(a);
    w.d = DW'(d);
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n && regWrite) begin
      ncommit1++;
      if (q1.size() == 0) begin
        chk("dut unexpected commit", 64'({writeReg, writeData}), 64'(0));
      end else begin
        wr_t e;
        e = q1.pop_front();
        chk("dut commit", 64'({writeReg, writeData}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_regWrite) begin
      ncommit0++;
      if (q0.size() == 0) begin
        chk("dut0 unexpected commit", 64'({b_writeReg, b_writeData}), 64'(0));
      end else begin
        wr_t e;
        e = q0.pop_front();
        chk("dut0 commit", 64'({b_writeReg, b_writeData}), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0;
    b_alu_valid = 1'b0; b_mem_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && (q1.size() != 0 || q0.size() != 0); k++) tick();
    chk("drain dut", 64'(q1.size()), 64'(0));
    chk("drain dut0", 64'(q0.size()), 64'(0));
    tick();
  endtask

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic [AW-1:0] r1, r2;
    logic          ear, emr, eh1;
    logic [DW-1:0] ef1;
    logic          eh2;
    logic [DW-1:0] ef2;
  } vec_t;

  function automatic vec_t mk(input logic av, input int aa, input int ad,
                              input logic mv, input int ma, input int md,
                              input int r1, input int r2,
                              input logic ear, input logic emr,
                              input logic eh1, input int ef1,
                              input logic eh2, input int ef2);
    vec_t v;
    v.av = av; v.aa = AW'(aa); v.ad = DW'(ad);
    v.mv = mv; v.ma = AW'(ma); v.md = DW'(md);
    v.r1 = AW'(r1); v.r2 = AW'(r2);
    v.ear = ear; v.emr = emr;
    v.eh1 = eh1; v.ef1 = DW'(ef1);
    v.eh2 = eh2; v.ef2 = DW'(ef2);
    return v;
  endfunction

  vec_t tbl[8];

  int ia, im, ja, jm;
  int s1, s0;
  logic ra, rm, rba, rbm;

  initial begin
    // Per-cycle vectors on dut (TIE_MEM=1); state carries between rows.
    tbl[0] = mk(1, 5, 'h1234, 0,  0, 0,      5,  0, 1, 1, 0, 0,      0, 0);
    tbl[1] = mk(0, 0, 0,      0,  0, 0,      5,  9, 1, 1, 1, 'h1234, 0, 0);
    tbl[2] = mk(1, 3, 'hA,    1,  3, 'hB,    3,  5, 1, 1, 0, 0,      0, 0);
    tbl[3] = mk(1, 9, 'hC,    1, 10, 'hD,    3,  9, 0, 1, 1, 'hA,    0, 0);
    tbl[4] = mk(1, 9, 'hC,    0,  0, 0,     10,  3, 1, 0, 1, 'hD,    1, 'hA);
    tbl[5] = mk(1, 0, 'hFFFF, 0,  0, 0,      0,  9, 0, 1, 0, 0,      1, 'hC);
    tbl[6] = mk(1, 0, 'hFFFF, 0,  0, 0,      0, 10, 1, 1, 0, 0,      0, 0);
    tbl[7] = mk(0, 0, 0,      0,  0, 0,      0,  9, 1, 1, 0, 0,      0, 0);

    rst_n = 1'b0;
    idle();
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    b_alu_addr = '0; b_alu_data = '0; b_mem_addr = '0; b_mem_data = '0;
    rd1 = '0; rd2 = '0;

    // Reset state
    tick(); tick();
    chk("reset regWrite", 64'(regWrite), 64'(0));
    chk("reset writeReg", 64'(writeReg), 64'(0));
    chk("reset writeData", 64'(writeData), 64'(0));
    chk("reset alu_ready", 64'(alu_ready), 64'(0));
    chk("reset mem_ready", 64'(mem_ready), 64'(0));
    chk("reset dut0 regWrite", 64'(b_regWrite), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("post-reset alu_ready", 64'(alu_ready), 64'(1));
    chk("post-reset mem_ready", 64'(mem_ready), 64'(1));

    // Table-driven sequence
    q1.push_back(wr(5, 'h1234));
    q1.push_back(wr(3, 'hB));
    q1.push_back(wr(3, 'hA));
    q1.push_back(wr(10, 'hD));
    q1.push_back(wr(9, 'hC));
    for (int i = 0; i < 8; i++) begin
      tick();
      alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
      rd1 = tbl[i].r1; rd2 = tbl[i].r2;
      #1;
      chk($sformatf("row%0d alu_ready", i), 64'(alu_ready), 64'(tbl[i].ear));
      chk($sformatf("row%0d mem_ready", i), 64'(mem_ready), 64'(tbl[i].emr));
      chk($sformatf("row%0d hit1", i), 64'(hit1), 64'(tbl[i].eh1));
      chk($sformatf("row%0d fwd1", i), 64'(fwd1), 64'(tbl[i].ef1));
      chk($sformatf("row%0d hit2", i), 64'(hit2), 64'(tbl[i].eh2));
      chk($sformatf("row%0d fwd2", i), 64'(fwd2), 64'(tbl[i].ef2));
    end
    idle();
    drain();

    // Single ALU write latency
    tick();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    q1.push_back(wr(5, 'h1234));
    #1;
    chk("lat alu_ready", 64'(alu_ready), 64'(1));
    tick();
    alu_valid = 1'b0;
    chk("lat edge1 regWrite", 64'(regWrite), 64'(0));
    tick();
    chk("lat edge2 regWrite", 64'(regWrite), 64'(1));
    chk("lat edge2 writeReg", 64'(writeReg), 64'(5));
    chk("lat edge2 writeData", 64'(writeData), 64'(32'h1234));
    tick();
    chk("lat idle regWrite", 64'(regWrite), 64'(0));
    chk("lat hold writeReg", 64'(writeReg), 64'(5));
    drain();

    // Same-edge tie on dut0 (ALU wins)
    tick();
    b_alu_valid = 1'b1; b_alu_addr = 5'd3; b_alu_data = 32'hA;
    b_mem_valid = 1'b1; b_mem_addr = 5'd3; b_mem_data = 32'hB;
    q0.push_back(wr(3, 'hA));
    q0.push_back(wr(3, 'hB));
    tick();
    idle();
    rd1 = 5'd3; rd2 = 5'd0;
    #1;
    chk("tie0 hit1", 64'(b_hit1), 64'(1));
    chk("tie0 fwd1 younger", 64'(b_fwd1), 64'(32'hB));
    chk("tie0 hit2 zero", 64'(b_hit2), 64'(0));
    chk("tie0 fwd2 zero", 64'(b_fwd2), 64'(0));
    chk("tie0 alu_ready", 64'(b_alu_ready), 64'(1));
    chk("tie0 mem_ready", 64'(b_mem_ready), 64'(0));
    drain();

    // MEM one edge before ALU to the same register
    tick();
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h1;
    q1.push_back(wr(7, 'h1));
    tick();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h2;
    q1.push_back(wr(7, 'h2));
    rd1 = 5'd7;
    #1;
    chk("order hit1 mem", 64'(hit1), 64'(1));
    chk("order fwd1 mem", 64'(fwd1), 64'(32'h1));
    tick();
    alu_valid = 1'b0;
    #1;
    chk("order hit1 alu", 64'(hit1), 64'(1));
    chk("order fwd1 alu", 64'(fwd1), 64'(32'h2));
    chk("order first data", 64'(writeData), 64'(32'h1));
    drain();

    // Flush with both slots full and ALU valid
    tick();
    alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h22;
    tick();
    mem_valid = 1'b0;
    alu_addr = 5'd13; alu_data = 32'h33;
    flush = 1'b1;
    #1;
    chk("flush alu_ready", 64'(alu_ready), 64'(0));
    chk("flush mem_ready", 64'(mem_ready), 64'(1));
    tick();
    idle();
    rd1 = 5'd13; rd2 = 5'd11;
    #1;
    chk("flush hit1 new", 64'(hit1), 64'(0));
    chk("flush hit2 old", 64'(hit2), 64'(0));
    chk("flush regWrite", 64'(regWrite), 64'(0));
    chk("flush alu_ready after", 64'(alu_ready), 64'(1));
    tick();
    chk("flush regWrite later", 64'(regWrite), 64'(0));
    tick(); tick();

    // Both requesters valid every cycle on both DUTs
    for (int i = 0; i < 11; i++) begin
      q1.push_back(wr(16 + i, 'hB000 + i));
      q1.push_back(wr(1 + i, 'hA000 + i));
      q0.push_back(wr(1 + i, 'hA000 + i));
      q0.push_back(wr(16 + i, 'hB000 + i));
    end
    ia = 0; im = 0; ja = 0; jm = 0;
    ra = 1'b0; rm = 1'b0; rba = 1'b0; rbm = 1'b0;
    s1 = 0; s0 = 0;
    for (int c = 0; c <= 20; c++) begin
      tick();
      if (ra) ia++;
      if (rm) im++;
      if (rba) ja++;
      if (rbm) jm++;
      if (c == 1) begin
        s1 = ncommit1;
        s0 = ncommit0;
      end
      alu_valid = 1'b1; alu_addr = AW'(1 + ia); alu_data = DW'('hA000 + ia);
      mem_valid = 1'b1; mem_addr = AW'(16 + im); mem_data = DW'('hB000 + im);
      b_alu_valid = 1'b1; b_alu_addr = AW'(1 + ja); b_alu_data = DW'('hA000 + ja);
      b_mem_valid = 1'b1; b_mem_addr = AW'(16 + jm); b_mem_data = DW'('hB000 + jm);
      #1;
      ra = alu_valid & alu_ready;
      rm = mem_valid & mem_ready;
      rba = b_alu_valid & b_alu_ready;
      rbm = b_mem_valid & b_mem_ready;
    end
    tick();
    if (ra) ia++;
    if (rm) im++;
    if (rba) ja++;
    if (rbm) jm++;
    idle();
    chk("stream dut commits in 20", 64'(ncommit1 - s1), 64'(20));
    chk("stream dut0 commits in 20", 64'(ncommit0 - s0), 64'(20));
    chk("stream dut alu accepts", 64'(ia), 64'(11));
    chk("stream dut mem accepts", 64'(im), 64'(11));
    chk("stream dut0 alu accepts", 64'(ja), 64'(11));
    chk("stream dut0 mem accepts", 64'(jm), 64'(11));
    drain();

    // Asynchronous reset while a write is on the port
    tick();
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h66;
    tick();
    idle();
    @(posedge clk);
    #2;
    chk("mid regWrite before reset", 64'(regWrite), 64'(1));
    chk("mid writeReg before reset", 64'(writeReg), 64'(6));
    chk("mid writeData before reset", 64'(writeData), 64'(32'h66));
    rst_n = 1'b0;
    #1;
    chk("async reset regWrite", 64'(regWrite), 64'(0));
    chk("async reset writeReg", 64'(writeReg), 64'(0));
    chk("async reset alu_ready", 64'(alu_ready), 64'(0));
    chk("async reset mem_ready", 64'(mem_ready), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    rd1 = 5'd4; rd2 = 5'd4;
    tick();
    chk("after reset regWrite", 64'(regWrite), 64'(0));
    chk("after reset alu_ready", 64'(alu_ready), 64'(1));
    chk("after reset hit1 lost", 64'(hit1), 64'(0));
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
